// File: rtl/esc_eepdone_pkg.sv
// -----------------------------------------------------------------------------
// esc_eepdone_pkg
// Shared definitions for the ESC EEPROM-done conditioner:
//   - Avalon-MM word addresses of the four slave registers
//   - bit positions inside the EDGE / MASK registers
//   - debounce FSM state encoding
// -----------------------------------------------------------------------------
package esc_eepdone_pkg;

    // Register map (word addresses on the 2-bit Avalon-MM address bus)
    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_CFG    = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_MASK   = 2'd3;

    // EDGE / MASK bit indices
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;

    // Debounce FSM states
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } deb_state_e;

endpackage : esc_eepdone_pkg

// File: rtl/esc_sync_chain.sv
// -----------------------------------------------------------------------------
// esc_sync_chain
// N-flop synchroniser bringing a single asynchronous bit into the clk domain.
// Every stage resets to RESET_VAL so the downstream logic sees a defined level
// while reset is held.
//
// Ports:
//   clk    in  1  destination clock
//   reset  in  1  asynchronous, active-high reset
//   i_d    in  1  asynchronous input bit
//   o_q    out 1  synchronised bit (last stage of the chain)
// -----------------------------------------------------------------------------
module esc_sync_chain #(
    parameter int unsigned N         = 2,   // number of flops, must be >= 2
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_chain;

    // NOTE: clocked state is always assigned with <= so every flop samples the
    // pre-edge value of its neighbours; '=' here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chain <= {N{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[N-2:0], i_d};
        end
    end

    assign o_q = r_chain[N-1];

endmodule : esc_sync_chain

// File: rtl/esc_eepdone_conditioner.sv
// -----------------------------------------------------------------------------
// esc_eepdone_conditioner
// Conditions the raw ESC EEPDONE pin for the EEPDONE input PIO: synchronises
// it into clk, debounces it with a programmable qualify count and drives the
// clean level out. Rise/fall events of the clean level are latched in a W1C
// EDGE register on a small Avalon-MM slave.
//
// Build option:
//   ESC_EEPDONE_IRQ_EN  when defined, adds the MASK register and a registered
//                       level interrupt irq = |(EDGE & MASK). When undefined,
//                       irq is tied 0 and address 3 reads 0 / ignores writes.
//
// Ports:
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   eepdone_async  in   1   raw EEPDONE pin, asynchronous to clk
//   eepdone_level  out  1   debounced level for the PIO in_port
//   address        in   2   Avalon-MM word address
//   chipselect     in   1   Avalon-MM select
//   write_n        in   1   Avalon-MM write strobe, active-low
//   writedata      in   32  Avalon-MM write data
//   readdata       out  32  Avalon-MM read data, one cycle latency, held
//   irq            out  1   level interrupt
//
// Registers:
//   0 STATUS RO  [0]=eepdone_level [1]=qualify in progress
//   1 CFG    RW  [DEB_W-1:0] qualify count in clk cycles
//   2 EDGE   W1C [0]=rise [1]=fall; a new event beats a clear in the same cycle
//   3 MASK   RW  [1:0] irq enable per EDGE bit
// -----------------------------------------------------------------------------
module esc_eepdone_conditioner
    import esc_eepdone_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 16,
    parameter int unsigned DEB_DEFAULT = 1000,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eepdone_async,
    output logic        eepdone_level,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [DEB_W-1:0] CFG_RST = DEB_W'(DEB_DEFAULT);
    localparam logic [DEB_W-1:0] CFG_ONE = DEB_W'(1);
    localparam logic [DEB_W:0]   CNT_TWO = (DEB_W+1)'(2);

    // ------------------------------------------------------------------
    // Synchroniser: the only consumer of eepdone_async
    // ------------------------------------------------------------------
    logic w_sync_q;

    esc_sync_chain #(
        .N         (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (eepdone_async),
        .o_q   (w_sync_q)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    deb_state_e       r_state;
    logic [DEB_W-1:0] r_cnt;
    logic             r_level;
    logic [DEB_W-1:0] r_cfg;
    logic [1:0]       r_edge;
    logic [31:0]      r_rdata;

    // ------------------------------------------------------------------
    // Debounce FSM: next-state logic
    // ------------------------------------------------------------------
    deb_state_e       w_state_nxt;
    logic [DEB_W-1:0] w_cnt_nxt;
    logic             w_commit;      // level register takes sync_q this cycle
    logic [DEB_W:0]   w_cnt_p2;

    // Commit when the incremented count would reach CFG-1, i.e. cnt+2 >= CFG.
    // Computed one bit wider so CFG=0 and a saturated counter cannot wrap.
    // The same compare finishes a qualify at once if CFG is lowered below
    // the running count.
    assign w_cnt_p2 = {1'b0, r_cnt} + CNT_TWO;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            ST_STABLE: begin
                w_cnt_nxt = '0;
                if (w_sync_q != r_level) begin
                    // CFG of 0 or 1 needs no qualify window at all
                    if (r_cfg <= CFG_ONE) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_nxt = ST_QUALIFY;
                    end
                end
            end
            ST_QUALIFY: begin
                if (w_sync_q == r_level) begin
                    // input returned before the window elapsed: glitch
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_p2 >= {1'b0, r_cfg}) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != {DEB_W{1'b1}}) begin
                    w_cnt_nxt = r_cnt + CFG_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_level <= RESET_LEVEL;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_commit) begin
                r_level <= w_sync_q;
            end
        end
    end

    assign eepdone_level = r_level;

    // ------------------------------------------------------------------
    // Avalon-MM slave
    // ------------------------------------------------------------------
    logic       w_wr;
    logic       w_rd;
    logic [1:0] w_edge_set;
    logic [1:0] w_edge_w1c;

    assign w_wr = chipselect && !write_n;
    assign w_rd = chipselect &&  write_n;

    // Events are flagged on the same edge the level register updates
    assign w_edge_set[EDGE_RISE] = w_commit &&  w_sync_q;
    assign w_edge_set[EDGE_FALL] = w_commit && !w_sync_q;
    assign w_edge_w1c = (w_wr && address == ADDR_EDGE) ? writedata[1:0] : 2'b00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg  <= CFG_RST;
            r_edge <= 2'b00;
        end else begin
            if (w_wr && address == ADDR_CFG) begin
                r_cfg <= writedata[DEB_W-1:0];
            end
            // set is OR-ed in after the clear so a coincident event survives
            r_edge <= (r_edge & ~w_edge_w1c) | w_edge_set;
        end
    end

`ifdef ESC_EEPDONE_IRQ_EN
    logic [1:0] r_mask;
    logic       r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= 2'b00;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && address == ADDR_MASK) begin
                r_mask <= writedata[1:0];
            end
            r_irq <= |(r_edge & r_mask);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // Read mux, sampled into readdata only on a read access
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_STATUS: w_rdata[1:0] = {(r_state == ST_QUALIFY), r_level};
            ADDR_CFG:    w_rdata[DEB_W-1:0] = r_cfg;
            ADDR_EDGE:   w_rdata[1:0] = r_edge;
`ifdef ESC_EEPDONE_IRQ_EN
            ADDR_MASK:   w_rdata[1:0] = r_mask;
`endif
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rdata;
        end
    end

    assign readdata = r_rdata;

    // Only writedata[DEB_W-1:0] and [1:0] carry register content
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata;

endmodule : esc_eepdone_conditioner

// File: tb/tb_esc_eepdone_conditioner.sv
// -----------------------------------------------------------------------------
// tb_esc_eepdone_conditioner
// Self-checking bench for esc_eepdone_conditioner with default parameters
// (SYNC_STAGES=2, DEB_W=16, DEB_DEFAULT=1000, RESET_LEVEL=0).
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge. Expected values are pushed into a scoreboard queue
// when stimulus is issued and popped when the DUT result is observed.
// -----------------------------------------------------------------------------
module tb_esc_eepdone_conditioner;

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_CFG    = 2'd1;
    localparam logic [1:0] A_EDGE   = 2'd2;
    localparam logic [1:0] A_MASK   = 2'd3;

    logic        clk;
    logic        reset;
    logic        eepdone_async;
    logic        eepdone_level;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];

    esc_eepdone_conditioner dut (
        .clk           (clk),
        .reset         (reset),
        .eepdone_async (eepdone_async),
        .eepdone_level (eepdone_level),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare against an observed value
    task automatic sb_check(input string tag, input logic [31:0] got);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", tag, got);
        end else begin
            check(tag, got, sb_q.pop_front());
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        chipselect = 1'b0;
        sb_check(tag, readdata);
    endtask

    // Falling edges until the level reaches tgt; -1 if the budget expires
    task automatic wait_level(input logic tgt, input int max_cyc, output int n);
        n = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (eepdone_level == tgt) begin
                n = i;
                break;
            end
        end
    endtask

    int lat;
    int n_tog;
    logic prev_level;

    initial begin
        reset         = 1'b1;
        eepdone_async = 1'b0;
        address       = 2'd0;
        chipselect    = 1'b0;
        write_n       = 1'b1;
        writedata     = 32'd0;
        repeat (2) @(negedge clk);

        // ---- reset state ----
        check("rst_level", {31'd0, eepdone_level}, 32'd0);
        check("rst_rdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        rd(A_STATUS, 32'h0,   "rst_status");
        rd(A_CFG,    32'd1000, "rst_cfg");
        rd(A_EDGE,   32'h0,   "rst_edge");
        rd(A_MASK,   32'h0,   "rst_mask");

        // ---- 1: CFG=4, rising pin, latency 2+4 ----
        wr(A_CFG, 32'd4);
        rd(A_CFG, 32'd4, "t1_cfg");
        eepdone_async = 1'b1;
        sb_q.push_back(32'd6);
        wait_level(1'b1, 50, lat);
        sb_check("t1_rise_latency", lat);
        repeat (4) @(negedge clk);
        rd(A_EDGE,   32'h1, "t1_edge");
        rd(A_STATUS, 32'h1, "t1_status");
        eepdone_async = 1'b0;
        sb_q.push_back(32'd6);
        wait_level(1'b0, 50, lat);
        sb_check("t1_fall_latency", lat);
        rd(A_EDGE, 32'h3, "t1_edge_both");

        // ---- 3: W1C, and fall event coincident with W1C of bit1 ----
        wr(A_EDGE, 32'h1);
        rd(A_EDGE, 32'h2, "t3_w1c_bit0");
        wr(A_CFG, 32'd0);
        wr(A_EDGE, 32'h3);
        rd(A_EDGE, 32'h0, "t3_cleared");
        eepdone_async = 1'b1;
        sb_q.push_back(32'd3);
        wait_level(1'b1, 50, lat);
        sb_check("t4_cfg0_latency", lat);
        wr(A_EDGE, 32'h1);
        eepdone_async = 1'b0;          // commit lands on the 3rd rising edge
        repeat (2) @(negedge clk);
        wr(A_EDGE, 32'h2);             // clear bit1 on that same edge
        check("t3_fell", {31'd0, eepdone_level}, 32'd0);
        rd(A_EDGE, 32'h2, "t3_set_wins");

        // ---- 2: CFG=4, 3-cycle glitch is rejected ----
        wr(A_CFG, 32'd4);
        wr(A_EDGE, 32'h3);
        eepdone_async = 1'b1;
        repeat (3) @(negedge clk);
        eepdone_async = 1'b0;
        rd(A_STATUS, 32'h2, "t2_status_qualify");
        repeat (5) @(negedge clk);
        rd(A_STATUS, 32'h0, "t2_status_idle");
        rd(A_EDGE,   32'h0, "t2_edge");
        check("t2_level", {31'd0, eepdone_level}, 32'd0);

        // ---- 4: CFG=0, toggle every 3 cycles, every toggle captured ----
        wr(A_CFG, 32'd0);
        wr(A_EDGE, 32'h3);
        n_tog = 0;
        prev_level = eepdone_level;
        sb_q.push_back(32'd4);
        for (int t = 0; t < 4; t++) begin
            eepdone_async = ~eepdone_async;
            repeat (3) begin
                @(negedge clk);
                if (eepdone_level != prev_level) n_tog++;
                prev_level = eepdone_level;
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (eepdone_level != prev_level) n_tog++;
            prev_level = eepdone_level;
        end
        sb_check("t4_toggles", n_tog);
        rd(A_EDGE, 32'h3, "t4_edge");

        // ---- 5: interrupt ----
`ifdef ESC_EEPDONE_IRQ_EN
        wr(A_MASK, 32'h1);
        rd(A_MASK, 32'h1, "t5_mask");
        wr(A_EDGE, 32'h3);
        eepdone_async = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_level_up", {31'd0, eepdone_level}, 32'd1);
        check("t5_irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("t5_irq_set", {31'd0, irq}, 32'd1);
        wr(A_EDGE, 32'h1);
        check("t5_irq_hold", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("t5_irq_clr", {31'd0, irq}, 32'd0);
        eepdone_async = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_fall_masked", {31'd0, irq}, 32'd0);
`else
        wr(A_MASK, 32'h3);
        rd(A_MASK, 32'h0, "t5_mask_absent");
        wr(A_EDGE, 32'h3);
        eepdone_async = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_irq_tied", {31'd0, irq}, 32'd0);
        rd(A_EDGE, 32'h1, "t5_edge_still");
        eepdone_async = 1'b0;
        repeat (6) @(negedge clk);
`endif

        // ---- CFG lowered mid-qualify: completes on the next cycle ----
        wr(A_CFG, 32'd20);
        eepdone_async = 1'b1;
        repeat (6) @(negedge clk);
        wr(A_CFG, 32'd2);
        check("t7_not_yet", {31'd0, eepdone_level}, 32'd0);
        @(negedge clk);
        check("t7_early_done", {31'd0, eepdone_level}, 32'd1);
        eepdone_async = 1'b0;
        sb_q.push_back(32'd4);
        wait_level(1'b0, 50, lat);
        sb_check("t7_cfg2_latency", lat);

        // ---- 6: reset mid-qualify (counter=2 of 4) ----
        wr(A_CFG, 32'd4);
        eepdone_async = 1'b1;
        repeat (4) @(negedge clk);
        rd(A_STATUS, 32'h2, "t6_in_qualify");
        reset = 1'b1;
        eepdone_async = 1'b0;
        @(negedge clk);
        check("t6_rst_level", {31'd0, eepdone_level}, 32'd0);
        check("t6_rst_rdata", readdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        rd(A_CFG,    32'd1000, "t6_cfg");
        rd(A_EDGE,   32'h0,    "t6_edge");
        rd(A_STATUS, 32'h0,    "t6_status");
        check("t6_irq", {31'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected summary");
        $fatal(1);
    end

endmodule : tb_esc_eepdone_conditioner
